// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked, pipelined add/subtract unit.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } add_op_e;

    // Bits resolved per pipeline stage.
    function automatic int chunk_count(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple-carry slice; also exposes the carry into
// its MSB so the final stage can derive two's-complement overflow.
module adder_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co       = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract pipelined over STAGES chunks, one chunk resolved per
// clock, with valid/ready on both sides and full back-pressure.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_count(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;

    if ((WIDTH < 2) || (STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES");
    end

    // Per-stage registered state.
    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic              ovf_q;

    // Per-stage combinational view of what the stage would load.
    logic [WIDTH-1:0]  a_in   [STAGES];
    logic [WIDTH-1:0]  b_in   [STAGES];
    logic [WIDTH-1:0]  s_prev [STAGES];
    logic [WIDTH-1:0]  s_nxt  [STAGES];
    logic [CHUNK-1:0]  s_chunk[STAGES];
    logic [STAGES-1:0] ci, co, c_msb, src_v, adv, ld;

    add_op_e          op;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign op    = add_op_e'(sub);
    assign b_eff = (op == OP_SUB) ? ~b : b;
    assign c0    = (op == OP_SUB) ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_in[k]   = a;
            assign b_in[k]   = b_eff;
            assign ci[k]     = c0;
            assign s_prev[k] = '0;
            assign src_v[k]  = in_valid;
        end else begin : g_body
            assign a_in[k]   = a_q[k-1];
            assign b_in[k]   = b_q[k-1];
            assign ci[k]     = c_q[k-1];
            assign s_prev[k] = s_q[k-1];
            assign src_v[k]  = v_q[k-1];
        end

        // A stage's contents move on if the consumer is ready or any later stage holds a bubble.
        if (k == LAST) begin : g_tail_adv
            assign adv[k] = out_ready;
        end else begin : g_mid_adv
            assign adv[k] = out_ready | ~(&v_q[LAST:k+1]);
        end

        assign ld[k] = ~v_q[k] | adv[k];

        adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a        (a_in[k][k*CHUNK +: CHUNK]),
            .b        (b_in[k][k*CHUNK +: CHUNK]),
            .ci       (ci[k]),
            .s        (s_chunk[k]),
            .co       (co[k]),
            .c_msb_in (c_msb[k])
        );

        // Chunks above k are still zero in s_prev, so OR-ing in the new chunk is enough.
        assign s_nxt[k] = s_prev[k] | (WIDTH'(s_chunk[k]) << (k * CHUNK));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only valid bits and visible output fields are reset; inner operand/sum registers are don't-care while their valid bit is low.
            v_q       <= '0;
            s_q[LAST] <= '0;
            c_q[LAST] <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    v_q[k] <= src_v[k];
                    if (src_v[k]) begin
                        a_q[k] <= a_in[k];
                        b_q[k] <= b_in[k];
                        s_q[k] <= s_nxt[k];
                        c_q[k] <= co[k];
                    end
                end
            end
            if (ld[LAST] && src_v[LAST]) begin
                ovf_q <= c_msb[LAST] ^ co[LAST];
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: latency, carry/overflow corners, back-pressure,
// mid-flight reset, plus 8/1 and 32/8 parameter instances against a reference model.
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a_drv, b_drv;
    logic        cin_drv, sub_drv;
    int          sel;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    logic        iv16, iv8, iv32;
    logic        rdy16, rdy8, rdy32;
    logic        ov16, ov8, ov32;
    logic [15:0] s16;
    logic [7:0]  s8;
    logic [31:0] s32;
    logic        co16, co8, co32, of16, of8, of32;

    assign iv16 = in_valid && (sel == 0);
    assign iv8  = in_valid && (sel == 1);
    assign iv32 = in_valid && (sel == 2);

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16),
        .a(a_drv[15:0]), .b(b_drv[15:0]), .cin(cin_drv), .sub(sub_drv),
        .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(co16), .ovf(of16)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8),
        .a(a_drv[7:0]), .b(b_drv[7:0]), .cin(cin_drv), .sub(sub_drv),
        .out_valid(ov8), .out_ready(out_ready), .sum(s8), .cout(co8), .ovf(of8)
    );

    pipelined_adder #(.WIDTH(32), .STAGES(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(rdy32),
        .a(a_drv), .b(b_drv), .cin(cin_drv), .sub(sub_drv),
        .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(co32), .ovf(of32)
    );

    logic        obs_in_ready, obs_valid, obs_cout, obs_ovf;
    logic [31:0] obs_sum;

    always_comb begin
        obs_in_ready = rdy16;
        obs_valid    = ov16;
        obs_sum      = 32'(s16);
        obs_cout     = co16;
        obs_ovf      = of16;
        case (sel)
            1: begin
                obs_in_ready = rdy8; obs_valid = ov8; obs_sum = 32'(s8);
                obs_cout = co8; obs_ovf = of8;
            end
            2: begin
                obs_in_ready = rdy32; obs_valid = ov32; obs_sum = s32;
                obs_cout = co32; obs_ovf = of32;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic, overflow from operand/result sign agreement.
    task automatic ref_model(input int w, input logic [31:0] aa, input logic [31:0] bb,
                             input logic c, input logic s, output logic [31:0] rs,
                             output logic rc, output logic ro);
        logic [63:0] mask, bn, full, a64;
        mask = (64'd1 << w) - 64'd1;
        a64  = {32'd0, aa} & mask;
        bn   = s ? (~{32'd0, bb} & mask) : ({32'd0, bb} & mask);
        full = a64 + bn + (s ? 64'd1 : {63'd0, c});
        rs   = 32'(full & mask);
        rc   = full[w];
        ro   = (a64[w-1] == bn[w-1]) && (full[w-1] != a64[w-1]);
    endtask

    // One isolated transaction on the selected DUT with latency measurement.
    task automatic run_one(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                           input logic c, input logic s, input int exp_lat,
                           input logic [31:0] e_sum, input logic e_cout, input logic e_ovf);
        int lat;
        @(negedge clk);
        a_drv = aa; b_drv = bb; cin_drv = c; sub_drv = s;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(obs_in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!obs_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_sum"}, 64'(obs_sum), 64'(e_sum));
        check({tag, "_cout"}, 64'(obs_cout), 64'(e_cout));
        check({tag, "_ovf"}, 64'(obs_ovf), 64'(e_ovf));
        @(negedge clk);
        check({tag, "_drained"}, 64'(obs_valid), 64'd0);
    endtask

    int          sent, recv, occ, seen;
    logic        in_fire, out_fire, prev_stall;
    logic [31:0] held;
    logic [31:0] ra, rb, rs;
    logic        rcin, rsub, rc, ro;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_drv = '0; b_drv = '0; cin_drv = 1'b0; sub_drv = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(obs_valid), 64'd0);
        check("rst_sum", 64'(obs_sum), 64'd0);
        check("rst_cout", 64'(obs_cout), 64'd0);
        check("rst_ovf", 64'(obs_ovf), 64'd0);
        check("rst_in_ready", 64'(obs_in_ready), 64'd1);

        // Directed corners on the 16/4 instance.
        run_one("add",      32'h1234, 32'h4321, 1'b0, 1'b0, 4, 32'h5555, 1'b0, 1'b0);
        run_one("carry_all", 32'hFFFF, 32'h0000, 1'b1, 1'b0, 4, 32'h0000, 1'b1, 1'b0);
        run_one("ovf_pos",  32'h7FFF, 32'h0001, 1'b0, 1'b0, 4, 32'h8000, 1'b0, 1'b1);
        run_one("sub_borrow", 32'h0005, 32'h0007, 1'b1, 1'b1, 4, 32'hFFFE, 1'b0, 1'b0);
        run_one("sub_ovf",  32'h8000, 32'h0001, 1'b0, 1'b1, 4, 32'h7FFF, 1'b1, 1'b1);

        // Back-to-back with a stall window on cycles 5..10.
        sent = 0; recv = 0; occ = 0; prev_stall = 1'b0; held = '0;
        cin_drv = 1'b0; sub_drv = 1'b0;
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                check("b2b_hold_valid", 64'(obs_valid), 64'd1);
                check("b2b_hold_sum", 64'(obs_sum), 64'(held));
            end
            out_ready = !(cyc >= 5 && cyc <= 10);
            in_valid  = (sent < 8);
            a_drv     = 32'(sent);
            b_drv     = 32'(sent * 3);
            #1;
            check("b2b_in_ready", 64'(obs_in_ready), 64'((occ < 4) || out_ready));
            in_fire  = in_valid && obs_in_ready;
            out_fire = obs_valid && out_ready;
            if (out_fire) begin
                check("b2b_sum", 64'(obs_sum), 64'(4 * recv));
                recv++;
            end
            prev_stall = obs_valid && !out_ready;
            held       = obs_sum;
            @(posedge clk);
            sent += int'(in_fire);
            occ  += int'(in_fire) - int'(out_fire);
        end
        check("b2b_count", 64'(recv), 64'd8);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_no_extra", 64'(obs_valid), 64'd0);

        // Reset with three results in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_drv = 32'h0100 + 32'(i);
            b_drv = 32'h0011;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", 64'(obs_valid), 64'd0);
        check("midrst_sum", 64'(obs_sum), 64'd0);
        check("midrst_cout", 64'(obs_cout), 64'd0);
        check("midrst_ovf", 64'(obs_ovf), 64'd0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (obs_valid) seen++;
        end
        check("midrst_none_emitted", 64'(seen), 64'd0);

        // WIDTH=8, STAGES=1.
        sel = 1;
        run_one("w8_sub_ovf", 32'h80, 32'h01, 1'b0, 1'b1, 1, 32'h7F, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            ra = $urandom & 32'hFF; rb = $urandom & 32'hFF;
            rcin = 1'($urandom); rsub = 1'($urandom);
            ref_model(8, ra, rb, rcin, rsub, rs, rc, ro);
            run_one("w8_rand", ra, rb, rcin, rsub, 1, rs, rc, ro);
        end

        // WIDTH=32, STAGES=8.
        sel = 2;
        run_one("w32_carry_all", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 8, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom;
            rcin = 1'($urandom); rsub = 1'($urandom);
            ref_model(32, ra, rb, rcin, rsub, rs, rc, ro);
            run_one("w32_rand", ra, rb, rcin, rsub, 8, rs, rc, ro);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
